// File: rtl/fft_reader_pkg.sv
// Shared types and helpers for the FFT result-RAM reader.
package fft_reader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StSettle,
    StStream,
    StDrain
  } rd_state_e;

  localparam int unsigned DefNPoints   = 16;
  localparam int unsigned DefDataW     = 32;
  localparam int unsigned DefSettleCyc = 2;
  localparam int unsigned DefFifoDepth = 2;
  localparam int unsigned MaxAddrW     = 16;

  // Reverses the low w bits of v; bits at and above w come back as zero.
  function automatic logic [MaxAddrW-1:0] bitrev(input logic [MaxAddrW-1:0] v,
                                                 input int unsigned w);
    logic [MaxAddrW-1:0] r;
    r = {<<{v}};
    return r >> (MaxAddrW - w);
  endfunction

endpackage

// File: rtl/fft_rd_fifo.sv
// Small output buffer for the result reader; the entry carries the data word plus its last flag.
module fft_rd_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 33
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     wr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     rd_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    cnt_q, cnt_d;
  logic             full, do_wr, do_rd;

  assign empty_o = (cnt_q == '0);
  assign full    = (cnt_q == (PtrW+1)'(DEPTH));
  assign do_rd   = rd_i & ~empty_o;
  assign do_wr   = wr_i & (~full | do_rd);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({do_wr, do_rd})
      2'b10:   cnt_d = cnt_q + (PtrW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PtrW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: the head is only observed while the FIFO is non-empty.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fft_result_reader.sv
// Streams a finished FFT result RAM to a valid/ready sink while holding the core in READ_RAM.
// SETTLE_CYC must be at least 1.
module fft_result_reader
  import fft_reader_pkg::*;
#(
  parameter int unsigned N_POINTS   = DefNPoints,
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned ADDR_W     = $clog2(N_POINTS),
  parameter bit          BIT_REV    = 1'b1,
  parameter int unsigned SETTLE_CYC = DefSettleCyc,
  parameter int unsigned FIFO_DEPTH = DefFifoDepth
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              done_i,
  input  logic              fetch_i,
  input  logic              abort_i,
  output logic              read_ram_o,
  output logic              ram_rd_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_last_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam int unsigned IdxW = ADDR_W + 1;
  localparam int unsigned SetW = $clog2(SETTLE_CYC + 1);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  rd_state_e         state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [SetW-1:0]   settle_q, settle_d;
  logic              read_ram_q, read_ram_d;
  logic              inflight_q, inflight_last_q, err_q;
  logic              issue, pop, flush, last_issue, fifo_empty;
  logic [CntW-1:0]   fifo_cnt;
  logic [CntW:0]     credit_used;
  logic [DATA_W:0]   fifo_head;
  logic [ADDR_W-1:0] nat_addr;

  assign pop        = ~fifo_empty & m_ready_i;
  assign flush      = abort_i & (state_q != StIdle);
  assign last_issue = (idx_q == IdxW'(N_POINTS - 1));
  // A beat leaving this cycle frees its slot, which keeps one read per cycle under full ready.
  assign credit_used = {1'b0, fifo_cnt} + (CntW+1)'(inflight_q) - (CntW+1)'(pop);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    issue    = 1'b0;
    unique case (state_q)
      StIdle: begin
        idx_d = '0;
        if (done_i) state_d = StArmed;
      end
      StArmed: begin
        settle_d = '0;
        if (fetch_i) state_d = StSettle;
      end
      StSettle: begin
        if (settle_q == SetW'(SETTLE_CYC - 1)) state_d = StStream;
        else settle_d = settle_q + SetW'(1);
      end
      StStream: begin
        if ((idx_q < IdxW'(N_POINTS)) && (credit_used < (CntW+1)'(FIFO_DEPTH))) begin
          issue = 1'b1;
          idx_d = idx_q + IdxW'(1);
          if (last_issue) state_d = StDrain;
        end
      end
      StDrain: begin
        if (pop & fifo_head[DATA_W]) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (flush) begin
      state_d = StIdle;
      idx_d   = '0;
      issue   = 1'b0;
    end
  end

  assign read_ram_d = (state_d == StSettle) || (state_d == StStream) || (state_d == StDrain);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= StIdle;
      idx_q           <= '0;
      settle_q        <= '0;
      read_ram_q      <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      settle_q        <= settle_d;
      read_ram_q      <= read_ram_d;
      inflight_q      <= issue;
      inflight_last_q <= issue & last_issue;
      if (done_i && (state_q != StIdle)) err_q <= 1'b1;
    end
  end

  fft_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W + 1)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush),
    .wr_i    (inflight_q),
    .wdata_i ({inflight_last_q, ram_rdata_i}),
    .rd_i    (m_ready_i),
    .rdata_o (fifo_head),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign nat_addr   = idx_q[ADDR_W-1:0];
  assign ram_addr_o = BIT_REV ? ADDR_W'(bitrev(MaxAddrW'(nat_addr), ADDR_W)) : nat_addr;
  assign ram_rd_o   = issue;
  assign read_ram_o = read_ram_q;
  assign m_valid_o  = ~fifo_empty;
  assign m_data_o   = m_valid_o ? fifo_head[DATA_W-1:0] : '0;
  assign m_last_o   = m_valid_o & fifo_head[DATA_W];
  assign busy_o     = (state_q != StIdle);
  assign err_o      = err_q;

endmodule

// File: tb/tb_fft_result_reader.sv
// Self-checking bench for fft_result_reader (N=16, bit-reversed addressing, RAM data = addr*3).
module tb_fft_result_reader;

  localparam int unsigned N  = 16;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;

  logic          clk_i = 1'b0;
  logic          rst_i, done_i, fetch_i, abort_i, m_ready_i;
  logic          read_ram_o, ram_rd_o, m_valid_o, m_last_o, busy_o, err_o;
  logic [AW-1:0] ram_addr_o;
  logic [DW-1:0] ram_rdata_i, m_data_o;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  typedef struct {
    int   pct;
    int   abort_at;
    bit   inj_done;
    int   exp_beats;
    logic exp_err;
  } vec_t;

  int          checks = 0;
  int          passed = 0;
  int          beats_rx = 0;
  int          rd_cnt = 0;
  logic [15:0] gen = 16'h0;
  beat_t       exp_q[$];
  bit          hold_pend = 1'b0;
  beat_t       hold_beat;

  always #5 clk_i = ~clk_i;

  fft_result_reader #(
    .N_POINTS   (16),
    .DATA_W     (32),
    .BIT_REV    (1'b1),
    .SETTLE_CYC (2),
    .FIFO_DEPTH (2)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .done_i      (done_i),
    .fetch_i     (fetch_i),
    .abort_i     (abort_i),
    .read_ram_o  (read_ram_o),
    .ram_rd_o    (ram_rd_o),
    .ram_addr_o  (ram_addr_o),
    .ram_rdata_i (ram_rdata_i),
    .m_valid_o   (m_valid_o),
    .m_ready_i   (m_ready_i),
    .m_data_o    (m_data_o),
    .m_last_o    (m_last_o),
    .busy_o      (busy_o),
    .err_o       (err_o)
  );

  // RAM model: one-cycle read latency, garbage when not read.
  always @(posedge clk_i) begin
    ram_rdata_i <= ram_rd_o ? {gen, 16'(ram_addr_o) * 16'd3} : 32'hDEAD_BEEF;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [AW-1:0] rev4(input logic [AW-1:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  function automatic beat_t exp_beat(input int k);
    beat_t b;
    b.data = {gen, 16'(rev4(AW'(k))) * 16'd3};
    b.last = (k == N - 1);
    return b;
  endfunction

  task automatic new_xfer();
    gen++;
    rd_cnt   = 0;
    beats_rx = 0;
    exp_q.delete();
    for (int k = 0; k < N; k++) exp_q.push_back(exp_beat(k));
  endtask

  task automatic kick();
    new_xfer();
    @(posedge clk_i); #1 done_i = 1'b1;
    @(posedge clk_i); #1 done_i = 1'b0; fetch_i = 1'b1;
    @(posedge clk_i); #1 fetch_i = 1'b0;
  endtask

  // Drives ready/abort/done until the reader is idle again; bounded.
  task automatic run_loop(input int pct, input int abort_at, input bit inj_done,
                          output int n_beats);
    bit aborted  = 1'b0;
    bit injected = 1'b0;
    bit fin      = 1'b0;
    for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
      done_i  = 1'b0;
      abort_i = 1'b0;
      if (aborted) begin
        chk("abort_idle", {busy_o, read_ram_o, m_valid_o, ram_rd_o}, 4'b0000);
        fin = 1'b1;
      end else if (!busy_o) begin
        fin = 1'b1;
      end else begin
        m_ready_i = ($urandom_range(99) < pct);
        if (inj_done && !injected && beats_rx >= 8) begin
          done_i   = 1'b1;
          injected = 1'b1;
        end
        if (abort_at >= 0 && beats_rx == abort_at) begin
          abort_i   = 1'b1;
          m_ready_i = 1'b0;
          aborted   = 1'b1;
        end
        @(posedge clk_i); #1;
      end
    end
    chk("no_timeout", fin, 1);
    n_beats   = beats_rx;
    done_i    = 1'b0;
    abort_i   = 1'b0;
    m_ready_i = 1'b1;
  endtask

  // Monitor: samples on the falling edge, between input updates and the transfer edge.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend) begin
          chk("stall_valid", m_valid_o, 1);
          chk("stall_beat", {m_last_o, m_data_o}, hold_beat);
        end
        if (ram_rd_o) begin
          chk("rd_in_range", rd_cnt < N, 1);
          chk("ram_addr", ram_addr_o, rev4(AW'(rd_cnt)));
          rd_cnt++;
        end
        if (m_valid_o && m_ready_i) begin
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL extra_beat: got beat 0x%0h, expected none at %0t",
                     {m_last_o, m_data_o}, $time);
          end else begin
            b = exp_q.pop_front();
            chk("beat", {m_last_o, m_data_o}, b);
          end
          beats_rx++;
        end
        hold_pend = m_valid_o && !m_ready_i && !abort_i;
        hold_beat = {m_last_o, m_data_o};
      end
    end
  end

  initial begin
    vec_t vecs[8];
    int   n;
    int   first_rr, first_v, last_c, idle_c;
    logic rr_prev, rr_at_idle;

    vecs[0] = '{100, -1, 1'b0, 16, 1'b0};
    vecs[1] = '{ 50, -1, 1'b0, 16, 1'b0};
    vecs[2] = '{100,  5, 1'b0,  5, 1'b0};
    vecs[3] = '{100, -1, 1'b0, 16, 1'b0};
    vecs[4] = '{ 25, -1, 1'b0, 16, 1'b0};
    vecs[5] = '{100,  0, 1'b0,  0, 1'b0};
    vecs[6] = '{ 60, 15, 1'b0, 15, 1'b0};
    vecs[7] = '{ 70, -1, 1'b1, 16, 1'b1};

    rst_i = 1'b1; done_i = 1'b0; fetch_i = 1'b0; abort_i = 1'b0; m_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_outs", {read_ram_o, ram_rd_o, ram_addr_o, m_valid_o, m_data_o, m_last_o,
                       busy_o, err_o}, 64'h0);
    rst_i = 1'b0;

    // Latency and back-to-back throughput with ready tied high.
    new_xfer();
    @(posedge clk_i); #1 done_i = 1'b1;
    @(posedge clk_i); #1 done_i = 1'b0;
    chk("armed_state", {busy_o, read_ram_o}, 2'b10);
    fetch_i = 1'b1;
    first_rr = -1; first_v = -1; last_c = -1; idle_c = -1;
    rr_prev = 1'b0; rr_at_idle = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk_i); #1;
      fetch_i = 1'b0;
      if (first_rr < 0 && read_ram_o) first_rr = c;
      if (first_v < 0 && m_valid_o) first_v = c;
      if (m_valid_o && m_last_o) last_c = c;
      if (idle_c < 0 && !busy_o) begin
        idle_c     = c;
        rr_at_idle = read_ram_o;
        chk("read_ram_before_idle", rr_prev, 1);
      end
      rr_prev = read_ram_o;
    end
    chk("first_read_ram_cycle", first_rr, 1);
    chk("first_valid_cycle", first_v, 5);
    chk("last_beat_cycle", last_c, 20);
    chk("idle_cycle", idle_c, 21);
    chk("read_ram_drop", rr_at_idle, 0);
    chk("lat_beats", beats_rx, N);
    chk("lat_reads", rd_cnt, N);

    // done_i and fetch_i together in IDLE: only arms.
    new_xfer();
    @(posedge clk_i); #1 done_i = 1'b1; fetch_i = 1'b1;
    @(posedge clk_i); #1 done_i = 1'b0;
    chk("combo_armed", {busy_o, read_ram_o}, 2'b10);
    @(posedge clk_i); #1 fetch_i = 1'b0;
    chk("combo_settle", {busy_o, read_ram_o}, 2'b11);
    run_loop(100, -1, 1'b0, n);
    chk("combo_beats", n, N);

    for (int v = 0; v < 8; v++) begin
      kick();
      run_loop(vecs[v].pct, vecs[v].abort_at, vecs[v].inj_done, n);
      chk("vec_beats", n, vecs[v].exp_beats);
      if (vecs[v].abort_at < 0) chk("vec_reads", rd_cnt, N);
      repeat (3) @(posedge clk_i);
      #1;
      chk("vec_err", err_o, vecs[v].exp_err);
      chk("vec_quiet", {busy_o, m_valid_o, read_ram_o}, 3'b000);
      exp_q.delete();
    end

    // Asynchronous reset in the middle of a stream.
    kick();
    for (int c = 0; c < 200 && beats_rx < 3; c++) begin
      @(posedge clk_i); #1;
    end
    chk("reached_beat3", beats_rx >= 3, 1);
    rst_i = 1'b1;
    #1;
    chk("rst_async", {read_ram_o, ram_rd_o, ram_addr_o, m_valid_o, m_data_o, m_last_o,
                      busy_o, err_o}, 64'h0);
    @(posedge clk_i); #1 rst_i = 1'b0;
    exp_q.delete();
    kick();
    run_loop(50, -1, 1'b0, n);
    chk("post_rst_beats", n, N);
    chk("post_rst_reads", rd_cnt, N);
    chk("post_rst_err", err_o, 0);

    for (int t = 0; t < 1000; t++) begin
      kick();
      run_loop(50, -1, 1'b0, n);
      chk("rand_beats", n, N);
    end
    chk("rand_reads", rd_cnt, N);
    chk("rand_err", err_o, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
